// File: rtl/spike_event_arbiter.sv
// spike_event_arbiter
//   Captures rising edges on four spike-detector flags, timestamps them with a
//   free-running counter and queues {detector, timestamp} events.
//   Each detector has one pending slot and a refractory timer. A round-robin
//   arbiter moves pending events into an output FIFO.
//
// Ports
//   clk_i        sole clock, rising edge
//   rst_ni       asynchronous active-low reset
//   en_i         enables new edge captures (existing state is kept when low)
//   spike_in_i   detector flags: bit0 neo, bit1 ado, bit2 aso, bit3 ed
//   evt_valid_o  event FIFO head is valid
//   evt_ready_i  consumer accepts the head event
//   evt_det_o    detector index of the head event
//   evt_ts_o     timestamp of the head event
//   evt_ovf_o    sticky: at least one capture dropped since reset
//   drop_cnt_o   saturating count of dropped captures (only when the
//                SPIKE_ARB_DROP_CNT_EN macro is defined)
//
// Build option: define SPIKE_ARB_DROP_CNT_EN to add drop_cnt_o and its counter.

module spike_event_arbiter #(
    parameter int TS_W       = 32,
    parameter int REFRACT    = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_i,
    input  logic [3:0]      spike_in_i,
    output logic            evt_valid_o,
    input  logic            evt_ready_i,
    output logic [1:0]      evt_det_o,
    output logic [TS_W-1:0] evt_ts_o,
    output logic            evt_ovf_o
`ifdef SPIKE_ARB_DROP_CNT_EN
    ,
    output logic [15:0]     drop_cnt_o
`endif
);

    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int EW = 2 + TS_W;
    localparam logic [15:0] REFR_LOAD = 16'(REFRACT);

    logic [TS_W-1:0] ts_cnt_q;
    logic [3:0]      prev_q, arm_q, arm_d, pending_q, pending_d;
    logic [3:0]      cap, drop;
    logic [TS_W-1:0] ts_hold_q [4];
    logic [TS_W-1:0] ts_hold_d [4];
    logic [15:0]     refr_q [4];
    logic [15:0]     refr_d [4];
    logic [1:0]      rr_q, rr_d;

    logic [EW-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_q, rd_q, rd_nxt;
    logic [AW:0]     cnt_q, cnt_d, cnt_after_pop;
    logic            fifo_full, push, pop;
    logic [EW-1:0]   head;

    logic            gnt_vld;
    logic [1:0]      gnt_idx, srch_idx;

    logic            evt_valid_q, evt_valid_d;
    logic [1:0]      evt_det_q, evt_det_d;
    logic [TS_W-1:0] evt_ts_q, evt_ts_d;
    logic            ovf_q;

    assign fifo_full = (cnt_q == (AW+1)'(FIFO_DEPTH));
    assign pop       = evt_valid_q & evt_ready_i;
    assign push      = gnt_vld;

    // arm_q keeps a flag that was already high at reset release from being
    // taken as a fresh edge; it arms once the flag has been seen low.
    always_comb begin
        arm_d = arm_q | ~spike_in_i;
        for (int i = 0; i < 4; i++) begin
            cap[i] = spike_in_i[i] & ~prev_q[i] & arm_q[i] & en_i & (refr_q[i] == '0);
        end
    end

    // Round-robin search starting at rr_q, the index after the last grant.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = 2'd0;
        srch_idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            srch_idx = rr_q + 2'(k);
            if (!gnt_vld && pending_q[srch_idx] && !fifo_full) begin
                gnt_vld = 1'b1;
                gnt_idx = srch_idx;
            end
        end
        rr_d = gnt_vld ? gnt_idx + 2'd1 : rr_q;
    end

    // A capture on a detector being granted in the same cycle refills the
    // slot rather than dropping; otherwise a capture onto a full slot drops.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            drop[i]      = cap[i] & pending_q[i] & ~(gnt_vld && (gnt_idx == 2'(i)));
            pending_d[i] = pending_q[i];
            ts_hold_d[i] = ts_hold_q[i];
            if (gnt_vld && (gnt_idx == 2'(i))) begin
                pending_d[i] = 1'b0;
            end
            if (cap[i]) begin
                pending_d[i] = 1'b1;
                if (!drop[i]) begin
                    ts_hold_d[i] = ts_cnt_q;
                end
            end
            if (cap[i]) begin
                refr_d[i] = REFR_LOAD;
            end else if (refr_q[i] != '0) begin
                refr_d[i] = refr_q[i] - 16'd1;
            end else begin
                refr_d[i] = '0;
            end
        end
    end

    // Output stage is loaded from the count before this cycle's push, so a
    // freshly written entry becomes visible one cycle after it is written.
    always_comb begin
        cnt_d         = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        cnt_after_pop = cnt_q - (AW+1)'(pop);
        rd_nxt        = pop ? rd_q + AW'(1) : rd_q;
        head          = mem_q[rd_nxt];
        evt_valid_d   = (cnt_after_pop != '0);
        evt_det_d     = evt_det_q;
        evt_ts_d      = evt_ts_q;
        if (evt_valid_d) begin
            evt_det_d = head[EW-1 -: 2];
            evt_ts_d  = head[TS_W-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_q] <= {gnt_idx, ts_hold_q[gnt_idx]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ts_cnt_q    <= '0;
            prev_q      <= '0;
            arm_q       <= '0;
            pending_q   <= '0;
            rr_q        <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            evt_valid_q <= 1'b0;
            evt_det_q   <= '0;
            evt_ts_q    <= '0;
            ovf_q       <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                ts_hold_q[i] <= '0;
                refr_q[i]    <= '0;
            end
        end else begin
            ts_cnt_q    <= ts_cnt_q + TS_W'(1);
            prev_q      <= spike_in_i;
            arm_q       <= arm_d;
            pending_q   <= pending_d;
            rr_q        <= rr_d;
            if (push) begin
                wr_q <= wr_q + AW'(1);
            end
            rd_q        <= rd_nxt;
            cnt_q       <= cnt_d;
            evt_valid_q <= evt_valid_d;
            evt_det_q   <= evt_det_d;
            evt_ts_q    <= evt_ts_d;
            ovf_q       <= ovf_q | (|drop);
            for (int i = 0; i < 4; i++) begin
                ts_hold_q[i] <= ts_hold_d[i];
                refr_q[i]    <= refr_d[i];
            end
        end
    end

    assign evt_valid_o = evt_valid_q;
    assign evt_det_o   = evt_det_q;
    assign evt_ts_o    = evt_ts_q;
    assign evt_ovf_o   = ovf_q;

`ifdef SPIKE_ARB_DROP_CNT_EN
    logic [15:0] drop_cnt_q;
    logic [2:0]  drop_n;
    logic [16:0] drop_sum;

    always_comb begin
        drop_n   = 3'(drop[0]) + 3'(drop[1]) + 3'(drop[2]) + 3'(drop[3]);
        drop_sum = {1'b0, drop_cnt_q} + 17'(drop_n);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_spike_event_arbiter.sv
module tb_spike_event_arbiter;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       en_i = 1'b1;
    logic [3:0] spike_in_i = 4'b0;
    logic       evt_ready_i = 1'b1;
    logic       evt_valid_o;
    logic [1:0] evt_det_o;
    logic [7:0] evt_ts_o;
    logic       evt_ovf_o;
`ifdef SPIKE_ARB_DROP_CNT_EN
    logic [15:0] drop_cnt_o;
`endif

    spike_event_arbiter #(.TS_W(8), .REFRACT(8), .FIFO_DEPTH(4)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .en_i        (en_i),
        .spike_in_i  (spike_in_i),
        .evt_valid_o (evt_valid_o),
        .evt_ready_i (evt_ready_i),
        .evt_det_o   (evt_det_o),
        .evt_ts_o    (evt_ts_o),
        .evt_ovf_o   (evt_ovf_o)
`ifdef SPIKE_ARB_DROP_CNT_EN
        ,
        .drop_cnt_o  (drop_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [3:0] mask;
        logic       en;
        logic [7:0] ts;
        logic [2:0] n_exp;
        logic [7:0] dets;   // expected det k at bits [2k+1:2k]
    } vec_t;

    vec_t       vecs [6];
    int         tests_run = 0;
    int         tests_failed = 0;
    logic [7:0] ts_m = 8'd0;      // model of ts_cnt: edges since reset release
    int         got_n;
    int         got_det [16];
    int         got_ts  [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        ts_m = ts_m + 8'd1;
    endtask

    task automatic do_reset();
        rst_ni      = 1'b0;
        spike_in_i  = 4'b0;
        evt_ready_i = 1'b1;
        en_i        = 1'b1;
        @(posedge clk_i);
        #1;
        chk("rst_valid", 32'(evt_valid_o), 32'd0);
        chk("rst_det",   32'(evt_det_o),   32'd0);
        chk("rst_ts",    32'(evt_ts_o),    32'd0);
        chk("rst_ovf",   32'(evt_ovf_o),   32'd0);
        rst_ni = 1'b1;
        ts_m   = 8'd0;
    endtask

    task automatic advance_to(input logic [7:0] t);
        int guard = 0;
        while (ts_m != t && guard < 300) begin
            tick();
            guard++;
        end
    endtask

    task automatic pulse(input logic [3:0] m, input logic [7:0] t);
        advance_to(t);
        spike_in_i = m;
        tick();
        spike_in_i = 4'b0;
    endtask

    // Samples each cycle; every sampled valid&ready is popped at the next edge.
    task automatic collect(input int budget);
        got_n = 0;
        for (int k = 0; k < 16; k++) begin
            got_det[k] = -1;
            got_ts[k]  = -1;
        end
        for (int c = 0; c < budget; c++) begin
            if (evt_valid_o && evt_ready_i) begin
                if (got_n < 16) begin
                    got_det[got_n] = int'(evt_det_o);
                    got_ts[got_n]  = int'(evt_ts_o);
                end
                got_n++;
            end
            tick();
        end
    endtask

    initial begin
        logic [7:0] t0;
        logic [7:0] d;

        vecs[0] = '{mask: 4'b0100, en: 1'b1, ts: 8'd10, n_exp: 3'd1, dets: 8'h02};
        vecs[1] = '{mask: 4'b1111, en: 1'b1, ts: 8'd5,  n_exp: 3'd4, dets: 8'hE4};
        vecs[2] = '{mask: 4'b1010, en: 1'b1, ts: 8'd20, n_exp: 3'd2, dets: 8'h0D};
        vecs[3] = '{mask: 4'b0001, en: 1'b1, ts: 8'd3,  n_exp: 3'd1, dets: 8'h00};
        vecs[4] = '{mask: 4'b1001, en: 1'b1, ts: 8'd7,  n_exp: 3'd2, dets: 8'h0C};
        vecs[5] = '{mask: 4'b0100, en: 1'b0, ts: 8'd9,  n_exp: 3'd0, dets: 8'h00};

        for (int v = 0; v < 6; v++) begin
            do_reset();
            en_i = vecs[v].en;
            pulse(vecs[v].mask, vecs[v].ts);
            chk($sformatf("v%0d_lat_n", v), 32'(evt_valid_o), 32'd0);
            tick();
            chk($sformatf("v%0d_lat_n1", v), 32'(evt_valid_o), 32'd0);
            tick();
            chk($sformatf("v%0d_lat_n2", v), 32'(evt_valid_o), 32'(vecs[v].n_exp != 0));
            collect(16);
            en_i = 1'b1;
            chk($sformatf("v%0d_count", v), 32'(got_n), 32'(vecs[v].n_exp));
            for (int k = 0; k < int'(vecs[v].n_exp); k++) begin
                d = vecs[v].dets >> (2 * k);
                chk($sformatf("v%0d_det%0d", v, k), 32'(got_det[k]), 32'(d[1:0]));
                chk($sformatf("v%0d_ts%0d", v, k), 32'(got_ts[k]), 32'(vecs[v].ts));
            end
        end

        // Refractory: REFRACT=8, pulses at 20, 24 (blocked), 29 (just clear).
        do_reset();
        evt_ready_i = 1'b0;
        pulse(4'b0001, 8'd20);
        pulse(4'b0001, 8'd24);
        pulse(4'b0001, 8'd29);
        evt_ready_i = 1'b1;
        collect(16);
        chk("refr_count", 32'(got_n), 32'd2);
        chk("refr_ts0", 32'(got_ts[0]), 32'd20);
        chk("refr_ts1", 32'(got_ts[1]), 32'd29);
        chk("refr_ovf", 32'(evt_ovf_o), 32'd0);

        // Backpressure: fill FIFO, fill pending slots, then drop on bit1.
        do_reset();
        evt_ready_i = 1'b0;
        pulse(4'b1111, 8'd2);
        pulse(4'b1111, 8'd12);
        advance_to(8'd16);
        chk("bp_valid", 32'(evt_valid_o), 32'd1);
        chk("bp_head_det", 32'(evt_det_o), 32'd0);
        chk("bp_head_ts", 32'(evt_ts_o), 32'd2);
        chk("bp_no_ovf", 32'(evt_ovf_o), 32'd0);
        pulse(4'b0010, 8'd22);
        chk("bp_ovf", 32'(evt_ovf_o), 32'd1);
`ifdef SPIKE_ARB_DROP_CNT_EN
        chk("bp_drop_cnt", 32'(drop_cnt_o), 32'd1);
`endif
        chk("bp_hold_det", 32'(evt_det_o), 32'd0);
        chk("bp_hold_ts", 32'(evt_ts_o), 32'd2);
        evt_ready_i = 1'b1;
        collect(40);
        chk("bp_count", 32'(got_n), 32'd8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("bp_det%0d", k), 32'(got_det[k]), 32'(k % 4));
            chk($sformatf("bp_ts%0d", k), 32'(got_ts[k]), (k < 4) ? 32'd2 : 32'd12);
        end

        // Reset mid-operation with three events queued and evt_ovf set.
        evt_ready_i = 1'b0;
        t0 = ts_m + 8'd12;
        pulse(4'b0111, t0);
        repeat (5) tick();
        chk("mid_valid_pre", 32'(evt_valid_o), 32'd1);
        chk("mid_ovf_pre", 32'(evt_ovf_o), 32'd1);
        spike_in_i = 4'b0111;
        #3;
        rst_ni = 1'b0;
        #1;
        chk("mid_valid_rst", 32'(evt_valid_o), 32'd0);
        chk("mid_ovf_rst", 32'(evt_ovf_o), 32'd0);
        chk("mid_ts_rst", 32'(evt_ts_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        ts_m   = 8'd0;
        repeat (10) tick();
        chk("mid_held_high", 32'(evt_valid_o), 32'd0);
        spike_in_i = 4'b0;
        pulse(4'b0001, 8'd14);
        tick();
        tick();
        chk("mid_new_valid", 32'(evt_valid_o), 32'd1);
        chk("mid_new_det", 32'(evt_det_o), 32'd0);
        chk("mid_new_ts", 32'(evt_ts_o), 32'd14);

        // Timestamp wrap with TS_W=8: bit3 at 255, bit1 at 0.
        do_reset();
        evt_ready_i = 1'b0;
        advance_to(8'd255);
        spike_in_i = 4'b1000;
        tick();
        spike_in_i = 4'b0010;
        tick();
        spike_in_i = 4'b0;
        evt_ready_i = 1'b1;
        collect(16);
        chk("wrap_count", 32'(got_n), 32'd2);
        chk("wrap_det0", 32'(got_det[0]), 32'd3);
        chk("wrap_ts0", 32'(got_ts[0]), 32'd255);
        chk("wrap_det1", 32'(got_det[1]), 32'd1);
        chk("wrap_ts1", 32'(got_ts[1]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/spike_event_arbiter.md
SPIKE_EVENT_ARBITER -- requirements
Module: spike_event_arbiter

Interface
REQ-001 Parameter TS_W, default 32, timestamp width in bits.
REQ-002 Parameter REFRACT, default 64, per-detector refractory period in clk cycles, valid range 1..65535.
REQ-003 Parameter FIFO_DEPTH, default 4, output event FIFO depth, power of two, minimum 2.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  high enables edge capture; low suppresses new captures only.
REQ-007 spike_in  input  4  detector flags, bit0 neo, bit1 ado, bit2 aso, bit3 ed.
REQ-008 evt_valid  output  1  event FIFO non-empty.
REQ-009 evt_ready  input  1  consumer accepts the head event when high together with evt_valid.
REQ-010 evt_det  output  2  detector index of the head event.
REQ-011 evt_ts  output  TS_W  timestamp of the head event.
REQ-012 evt_ovf  output  1  sticky flag: at least one event dropped since reset.

Function
REQ-013 A free-running counter ts_cnt (TS_W bits) SHALL increment every cycle and wrap from all-ones to 0.
REQ-014 Per detector, a capture SHALL occur in the cycle in which spike_in[i] is 1, its registered previous value is 0, en is 1, and the refractory counter of i is 0.
REQ-015 On capture, pending[i] SHALL be set, ts_cnt SHALL be latched into ts_hold[i], and refr[i] SHALL be loaded with REFRACT.
REQ-016 refr[i] SHALL decrement by 1 per cycle while nonzero and saturate at 0.
REQ-017 A capture condition met while pending[i] is already 1 SHALL be dropped, set evt_ovf, and leave ts_hold[i] unchanged.
REQ-018 Each cycle in which the FIFO is not full and any pending bit is 1, exactly one detector SHALL be granted by round-robin, searching from the index after the last grant (wrapping 3->0; index 0 searched first after reset).
REQ-019 A grant SHALL push {i, ts_hold[i]} into the FIFO and clear pending[i] in the same cycle.
REQ-020 A capture and a grant of the same detector in the same cycle SHALL push the old entry and leave pending[i] set with the new timestamp; no drop occurs.
REQ-021 FIFO full: no grant occurs and pending bits hold; FIFO pop on evt_valid and evt_ready frees a slot usable by a grant in the next cycle.
REQ-022 evt_det and evt_ts SHALL be the FIFO head, driven from registers, and SHALL hold stable while evt_valid is 1 and evt_ready is 0.
REQ-023 Latency: spike_in[i] first sampled high at edge N, with the FIFO empty and no contention, SHALL give evt_valid=1 after edge N+2, with evt_ts equal to the ts_cnt value sampled at edge N.
REQ-024 Deasserting en SHALL not clear pending entries, the FIFO or the refractory counters.

Reset
REQ-025 rst low SHALL immediately clear ts_cnt, pending, ts_hold, refr, the previous-sample registers, the round-robin pointer and the FIFO pointers.
REQ-026 During reset, evt_valid, evt_det, evt_ts and evt_ovf SHALL be 0.
REQ-027 After rst is released, spike_in held high SHALL not produce a capture until it has been low for at least one cycle.

Configuration
REQ-028 With macro SPIKE_ARB_DROP_CNT_EN defined, output drop_cnt (16 bits) SHALL count dropped captures, saturate at 0xFFFF and be cleared by reset.
REQ-029 Without SPIKE_ARB_DROP_CNT_EN, drop_cnt SHALL be absent from the port list and no counter logic SHALL exist; evt_ovf behaviour is identical.

Verification
REQ-030 Single pulse: bit2 rises at ts_cnt=10, evt_ready=1 -> one event with evt_det=2 and evt_ts=10, visible two cycles later.
REQ-031 Simultaneous: all four bits rise together at ts_cnt=5 -> four events with det order 0,1,2,3, all with evt_ts=5.
REQ-032 Refractory: REFRACT=8, bit0 pulses at ts 0 and 4 -> one event (ts 0); a further pulse at ts 9 -> second event (ts 9).
REQ-033 Backpressure: evt_ready=0, FIFO_DEPTH=4, bits 0..3 each pulse twice with REFRACT spacing -> 4 events in FIFO, 4 held pending, no drops; a third pulse on bit1 -> evt_ovf=1 and drop_cnt=1.
REQ-034 Reset mid-operation: rst low while 3 events are queued -> evt_valid=0 and evt_ovf=0 immediately; after release, no event appears until a new rising edge.
REQ-035 Wrap: TS_W=8, a pulse at ts_cnt=255 and another on a different detector at ts_cnt=0 -> events with evt_ts 255 then 0.
